// File: rtl/iob_acc_sweep.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | iob_acc_sweep: programmable arithmetic sweep generator.                   |
// | The output is a valid/ready stream that the consumer can stall.           |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module iob_acc_sweep #(
    parameter int DATA_W = 21,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              cke_i,
    input  logic [DATA_W-1:0] start_i,
    input  logic [DATA_W-1:0] stride_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic [CNT_W-1:0]  loops_i,
    input  logic              go_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]        state_q,  state_d;
    logic [DATA_W-1:0] acc_q,    acc_d;
    logic [DATA_W-1:0] start_q,  start_d;
    logic [DATA_W-1:0] stride_q, stride_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [CNT_W-1:0]  loops_q,  loops_d;
    logic [CNT_W-1:0]  step_q,   step_d;
    logic [CNT_W-1:0]  loop_q,   loop_d;
    logic              done_q,   done_d;

    logic              acc_load;
    logic              acc_en;
    logic [DATA_W-1:0] acc_load_val;
    logic              last_step;
    logic              last_loop;

    assign last_step = (step_q == (count_q - CNT_W'(1)));
    assign last_loop = (loop_q == (loops_q - CNT_W'(1)));

    always_comb begin
        state_d      = state_q;
        start_d      = start_q;
        stride_d     = stride_q;
        count_d      = count_q;
        loops_d      = loops_q;
        step_d       = step_q;
        loop_d       = loop_q;
        done_d       = done_q;
        acc_load     = 1'b0;
        acc_en       = 1'b0;
        acc_load_val = start_q;
        if (cke_i) begin
            done_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (go_i && !abort_i) begin
                        start_d      = start_i;
                        stride_d     = stride_i;
                        count_d      = count_i;
                        loops_d      = loops_i;
                        step_d       = '0;
                        loop_d       = '0;
                        acc_load     = 1'b1;
                        acc_load_val = start_i;
                        if ((count_i == '0) || (loops_i == '0)) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (ready_i) begin
                        if (!last_step) begin
                            acc_en = 1'b1;
                            step_d = step_q + CNT_W'(1);
                        end else if (!last_loop) begin
                            acc_load = 1'b1;
                            step_d   = '0;
                            loop_d   = loop_q + CNT_W'(1);
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                    // Abort ends the sweep silently, even on the final transfer.
                    if (abort_i) begin
                        state_d = S_IDLE;
                        done_d  = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Accumulator datapath: load wins over the add.
    always_comb begin
        acc_d = acc_q;
        if (acc_load) begin
            acc_d = acc_load_val;
        end else if (acc_en) begin
            acc_d = acc_q + stride_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            start_q  <= '0;
            stride_q <= '0;
            count_q  <= '0;
            loops_q  <= '0;
            step_q   <= '0;
            loop_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            start_q  <= start_d;
            stride_q <= stride_d;
            count_q  <= count_d;
            loops_q  <= loops_d;
            step_q   <= step_d;
            loop_q   <= loop_d;
            done_q   <= done_d;
        end
    end

    assign busy_o  = (state_q == S_RUN);
    assign valid_o = (state_q == S_RUN);
    assign done_o  = done_q;
    assign data_o  = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_iob_acc_sweep.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_iob_acc_sweep: scoreboard bench for iob_acc_sweep.                     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_iob_acc_sweep;

    localparam int DATA_W = 21;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rstn_i = 1'b0;
    logic              cke_i = 1'b1;
    logic [DATA_W-1:0] start_i = '0;
    logic [DATA_W-1:0] stride_i = '0;
    logic [CNT_W-1:0]  count_i = '0;
    logic [CNT_W-1:0]  loops_i = '0;
    logic              go_i = 1'b0;
    logic              abort_i = 1'b0;
    logic              ready_i = 1'b1;
    logic              busy_o;
    logic              done_o;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] exp_q[$];

    iob_acc_sweep #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i   (clk),
        .rstn_i  (rstn_i),
        .cke_i   (cke_i),
        .start_i (start_i),
        .stride_i(stride_i),
        .count_i (count_i),
        .loops_i (loops_i),
        .go_i    (go_i),
        .abort_i (abort_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every accepted transfer is popped from the scoreboard; stalls must hold data.
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;
    always @(negedge clk) begin
        if (prev_stall && valid_o && rstn_i) begin
            check("stall_hold", data_o, prev_data);
        end
        prev_stall = valid_o && rstn_i && !(ready_i && cke_i);
        prev_data  = data_o;
        if (valid_o && ready_i && cke_i && rstn_i) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_xfer: got 0x%0h, expected no transfer", data_o);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (data_o !== e) begin
                    n_fail++;
                    $display("FAIL xfer_data: got 0x%0h, expected 0x%0h", data_o, e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [DATA_W-1:0] s, input logic [DATA_W-1:0] st,
                           input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] l);
        start_i  = s;
        stride_i = st;
        count_i  = c;
        loops_i  = l;
    endtask

    task automatic scramble_cfg();
        set_cfg(DATA_W'($urandom), DATA_W'($urandom), CNT_W'($urandom), CNT_W'($urandom));
    endtask

    task automatic do_go(input logic [DATA_W-1:0] s, input logic [DATA_W-1:0] st,
                         input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] l);
        set_cfg(s, st, c, l);
        go_i = 1'b1;
        cyc();
        go_i = 1'b0;
        scramble_cfg();
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy_o && k < 200) begin
            cyc();
            k++;
        end
        n_tests++;
        if (busy_o) begin
            n_fail++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, k);
        end
        check({name, "_drained"}, DATA_W'(exp_q.size()), '0);
    endtask

    initial begin
        int dones;
        rstn_i = 1'b0;
        cyc();
        cyc();
        check("rst_valid", DATA_W'(valid_o), '0);
        check("rst_busy",  DATA_W'(busy_o),  '0);
        check("rst_done",  DATA_W'(done_o),  '0);
        check("rst_data",  data_o,           '0);
        rstn_i = 1'b1;
        cyc();

        // Basic sweep with a back-to-back go in the done cycle.
        ready_i = 1'b1;
        exp_q.push_back(21'd5); exp_q.push_back(21'd8);
        exp_q.push_back(21'd11); exp_q.push_back(21'd14);
        do_go(21'd5, 21'd3, 16'd4, 16'd1);
        check("basic_first_valid", DATA_W'(valid_o), 21'd1);
        check("basic_first_data",  data_o,           21'd5);
        check("basic_busy",        DATA_W'(busy_o),  21'd1);
        cyc(); cyc(); cyc(); cyc();
        check("basic_done",        DATA_W'(done_o),  21'd1);
        check("basic_end_valid",   DATA_W'(valid_o), 21'd0);
        check("basic_end_busy",    DATA_W'(busy_o),  21'd0);
        exp_q.push_back(21'd2); exp_q.push_back(21'd2);
        do_go(21'd2, 21'd1, 16'd1, 16'd2);
        check("b2b_done_low", DATA_W'(done_o),  21'd0);
        check("b2b_valid",    DATA_W'(valid_o), 21'd1);
        wait_idle("b2b");
        cyc();

        // Loops with toggling backpressure.
        exp_q.push_back(21'h10); exp_q.push_back(21'h11);
        exp_q.push_back(21'h10); exp_q.push_back(21'h11);
        exp_q.push_back(21'h10); exp_q.push_back(21'h11);
        ready_i = 1'b1;
        do_go(21'h10, 21'd1, 16'd2, 16'd3);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            ready_i = ~ready_i;
            if (done_o) dones++;
        end
        check("loops_done_count", DATA_W'(dones), 21'd1);
        check("loops_drained",    DATA_W'(exp_q.size()), 21'd0);
        ready_i = 1'b1;

        // Wrap-around and negative stride.
        exp_q.push_back(21'h1FFFFE); exp_q.push_back(21'h000000); exp_q.push_back(21'h000002);
        do_go(21'h1FFFFE, 21'd2, 16'd3, 16'd1);
        wait_idle("wrap");
        cyc();
        exp_q.push_back(21'd1); exp_q.push_back(21'd0); exp_q.push_back(21'h1FFFFF);
        do_go(21'd1, 21'h1FFFFF, 16'd3, 16'd1);
        wait_idle("neg");
        cyc();

        // Degenerate go: no values, immediate done.
        do_go(21'd9, 21'd1, 16'd0, 16'd5);
        check("degen_done",  DATA_W'(done_o),  21'd1);
        check("degen_valid", DATA_W'(valid_o), 21'd0);
        check("degen_busy",  DATA_W'(busy_o),  21'd0);
        cyc();
        check("degen_done_clr", DATA_W'(done_o), 21'd0);
        do_go(21'd9, 21'd1, 16'd3, 16'd0);
        check("degen_loops_done", DATA_W'(done_o), 21'd1);
        check("degen_loops_busy", DATA_W'(busy_o), 21'd0);
        cyc();

        // go during RUN is ignored.
        exp_q.push_back(21'd100); exp_q.push_back(21'd110); exp_q.push_back(21'd120);
        exp_q.push_back(21'd130); exp_q.push_back(21'd140);
        do_go(21'd100, 21'd10, 16'd5, 16'd1);
        cyc();
        set_cfg(21'd7, 21'd7, 16'd9, 16'd9);
        go_i = 1'b1;
        cyc();
        go_i = 1'b0;
        wait_idle("ignored_go");
        cyc();

        // Abort on the 2nd of 8 transfers, then a clean restart.
        exp_q.push_back(21'd7); exp_q.push_back(21'd8);
        do_go(21'd7, 21'd1, 16'd8, 16'd1);
        cyc();
        abort_i = 1'b1;
        cyc();
        abort_i = 1'b0;
        check("abort_valid", DATA_W'(valid_o), 21'd0);
        check("abort_busy",  DATA_W'(busy_o),  21'd0);
        check("abort_done",  DATA_W'(done_o),  21'd0);
        cyc();
        check("abort_done_late", DATA_W'(done_o), 21'd0);
        check("abort_drained",   DATA_W'(exp_q.size()), 21'd0);
        exp_q.push_back(21'd7); exp_q.push_back(21'd8);
        do_go(21'd7, 21'd1, 16'd2, 16'd1);
        check("restart_data", data_o, 21'd7);
        wait_idle("restart");
        cyc();

        // Abort overrides go in IDLE.
        set_cfg(21'd3, 21'd1, 16'd2, 16'd1);
        go_i = 1'b1;
        abort_i = 1'b1;
        cyc();
        go_i = 1'b0;
        abort_i = 1'b0;
        check("abort_go_valid", DATA_W'(valid_o), 21'd0);
        check("abort_go_done",  DATA_W'(done_o),  21'd0);

        // Reset mid-sweep.
        exp_q.push_back(21'd50);
        do_go(21'd50, 21'd1, 16'd10, 16'd1);
        cyc();
        rstn_i = 1'b0;
        cyc();
        check("mrst_valid", DATA_W'(valid_o), 21'd0);
        check("mrst_busy",  DATA_W'(busy_o),  21'd0);
        check("mrst_done",  DATA_W'(done_o),  21'd0);
        check("mrst_data",  data_o,           21'd0);
        rstn_i = 1'b1;
        cyc();
        check("mrst_done_after", DATA_W'(done_o), 21'd0);
        check("mrst_drained",    DATA_W'(exp_q.size()), 21'd0);

        // Clock-enable freeze mid-sweep.
        exp_q.push_back(21'h100); exp_q.push_back(21'h104); exp_q.push_back(21'h108);
        exp_q.push_back(21'h10C); exp_q.push_back(21'h110); exp_q.push_back(21'h114);
        do_go(21'h100, 21'd4, 16'd6, 16'd1);
        cyc();
        cyc();
        cke_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("cke_hold_data",  data_o,           21'h108);
            check("cke_hold_valid", DATA_W'(valid_o), 21'd1);
        end
        cke_i = 1'b1;
        wait_idle("cke");
        check("cke_done", DATA_W'(done_o), 21'd1);
        cke_i = 1'b0;
        cyc();
        check("cke_done_stretch", DATA_W'(done_o), 21'd1);
        cke_i = 1'b1;
        cyc();
        check("cke_done_clr", DATA_W'(done_o), 21'd0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
